// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage and IF/ID pipeline register of the
// 16-bit five-stage core.
//
// Holds the PC, presents it to a combinational-read instruction memory and
// registers each returned word together with its PC+1. The second word of a
// two-word (immediate) instruction is tagged with if_id_imm so decode treats
// it as data rather than an opcode.
//
// Per-edge priority: branch_taken > stall > (interrupt) > normal fetch.
//
// Optional feature: define FETCH_INT_EN to add a level-sensitive interrupt
// input that vectors the PC between instructions (never between the halves of
// a two-word instruction).
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   asynchronous active-low reset
//   stall          in   hold PC, IF/ID and the pending-immediate flag
//   branch_taken   in   redirect request (wins over stall)
//   branch_target  in   redirect address
//   imem_addr      out  instruction memory address (= PC)
//   imem_data      in   word at imem_addr, same cycle
//   if_id_instr    out  registered instruction word
//   if_id_pc_next  out  registered PC+1 of that word
//   if_id_imm      out  registered immediate-extension tag
//   if_id_valid    out  registered: IF/ID holds a real fetched word
//   int_req        in   (FETCH_INT_EN) interrupt request, level
//   int_vector     in   (FETCH_INT_EN) interrupt handler address
//   int_ack        out  (FETCH_INT_EN) one-cycle pulse when taken
//   int_ret_pc     out  (FETCH_INT_EN) PC of the first unfetched word
module fetch_stage #(
    parameter int              PC_W         = 16,
    parameter logic [PC_W-1:0] RESET_PC     = '0,
    parameter logic [15:0]     IMM_OPC_MASK = 16'h0000,
    parameter logic [15:0]     NOP_WORD     = 16'h0000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_data,
    output logic [15:0]     if_id_instr,
    output logic [PC_W-1:0] if_id_pc_next,
    output logic            if_id_imm,
    output logic            if_id_valid
`ifdef FETCH_INT_EN
    ,
    input  logic            int_req,
    input  logic [PC_W-1:0] int_vector,
    output logic            int_ack,
    output logic [PC_W-1:0] int_ret_pc
`endif
);

    typedef struct packed {
        logic [15:0]     instr;
        logic [PC_W-1:0] pcNext;
        logic            imm;
        logic            valid;
    } ifIdT;

    localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};
    localparam ifIdT            IFID_NOP = '{instr: NOP_WORD, pcNext: '0,
                                            imm: 1'b0, valid: 1'b0};

    logic [PC_W-1:0] pc, pcD, pcPlus1;
    ifIdT            ifId, ifIdD;
    logic            immPending, immPendingD;
    logic            opcHasImm;

`ifdef FETCH_INT_EN
    logic            intAck, intAckD;
    logic [PC_W-1:0] intRetPc, intRetPcD;
`endif

    assign pcPlus1   = pc + PC_ONE;
    assign opcHasImm = IMM_OPC_MASK[imem_data[15:12]];

    always_comb begin
        pcD         = pc;
        ifIdD       = ifId;
        immPendingD = immPending;
`ifdef FETCH_INT_EN
        intAckD     = 1'b0;
        intRetPcD   = intRetPc;
`endif
        if (branch_taken) begin
            // Word at the current PC is discarded; any half-fetched pair is
            // abandoned so the target word decodes as an opcode.
            pcD         = branch_target;
            ifIdD       = IFID_NOP;
            immPendingD = 1'b0;
        end else if (stall) begin
            // hold everything
        end
`ifdef FETCH_INT_EN
        // !intAck keeps a held request from firing on back-to-back edges;
        // !immPending keeps the interrupt off the extension word.
        else if (int_req && !immPending && !intAck) begin
            pcD       = int_vector;
            intRetPcD = pc;
            ifIdD     = IFID_NOP;
            intAckD   = 1'b1;
        end
`endif
        else begin
            pcD          = pcPlus1;
            ifIdD.instr  = imem_data;
            ifIdD.pcNext = pcPlus1;
            ifIdD.valid  = 1'b1;
            ifIdD.imm    = immPending;
            // An extension word never arms a new pair, whatever its nibble.
            immPendingD  = !immPending && opcHasImm;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc         <= RESET_PC;
            ifId       <= IFID_NOP;
            immPending <= 1'b0;
        end else begin
            pc         <= pcD;
            ifId       <= ifIdD;
            immPending <= immPendingD;
        end
    end

`ifdef FETCH_INT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            intAck   <= 1'b0;
            intRetPc <= '0;
        end else begin
            intAck   <= intAckD;
            intRetPc <= intRetPcD;
        end
    end

    assign int_ack    = intAck;
    assign int_ret_pc = intRetPc;
`endif

    assign imem_addr     = pc;
    assign if_id_instr   = ifId.instr;
    assign if_id_pc_next = ifId.pcNext;
    assign if_id_imm     = ifId.imm;
    assign if_id_valid   = ifId.valid;

endmodule
